// File: rtl/parity_gen_check.sv
// Streaming parity generator/checker: one registered stage on a valid/ready link,
// per-word parity with even/odd sense, saturating error count and per-frame parity.
module parity_gen_check #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  input  logic              err_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              out_last,
  output logic              out_frame_par,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic accept;
  logic data_red;
  logic par;
  logic err;
  logic acc;

  assign in_ready = !rst & (!out_valid | out_ready);

  always_comb begin
    data_red = ^in_data;
    par      = data_red ^ odd;
    err      = (in_par != par);
    accept   = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_par       <= 1'b0;
      out_err       <= 1'b0;
      out_last      <= 1'b0;
      out_frame_par <= 1'b0;
      acc           <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_par   <= par;
      out_err   <= err;
      out_last  <= in_last;
      // frame parity uses the sense sampled on the closing beat
      if (in_last) begin
        out_frame_par <= acc ^ data_red ^ odd;
        acc           <= 1'b0;
      end else begin
        out_frame_par <= 1'b0;
        acc           <= acc ^ data_red;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // clear wins over a same-cycle error so software sees a clean zero
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (accept && err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
